// File: rtl/board_mac_array.sv
// board_mac_array
//   Multi-lane signed multiply-accumulate engine. Operand pairs arrive on a
//   valid/ready stream. Each lane accumulates its products over a frame of
//   frame_len beats and then presents one result vector per frame.
//   BOARD_VERSION selects how many lanes are built: 0 = lower half, 1 = all.
//
// Ports
//   clk100     : clock, all logic on the rising edge
//   rst        : asynchronous active-high reset
//   frame_len  : beats per frame, sampled on the first beat (0 means 1)
//   in_valid   : input beat valid
//   in_ready   : engine can accept a beat
//   in_a/in_b  : lane i signed operands at [i*DW +: DW]
//   out_valid  : result vector valid
//   out_ready  : consumer accepts the result vector
//   out_acc    : lane i signed result at [i*ACC_W +: ACC_W]
//   out_ovf    : lane i overflowed at least once during the frame
//   busy       : engine is not idle
module board_mac_array #(
  parameter int BOARD_VERSION = 0,
  parameter int NCH           = 4,
  parameter int DW            = 8,
  parameter int ACC_W         = 24,
  parameter int SATURATE      = 1
) (
  input  logic                 clk100,
  input  logic                 rst,
  input  logic [15:0]          frame_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*DW-1:0]    in_a,
  input  logic [NCH*DW-1:0]    in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*ACC_W-1:0] out_acc,
  output logic [NCH-1:0]       out_ovf,
  output logic                 busy
);

  localparam int NBUILT = (BOARD_VERSION == 1) ? NCH : NCH / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_en;
  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic        r_s1_v;
  logic        r_s2_v;
  logic        r_s3_v;
  logic [15:0] w_len_new;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_pipe_empty;
  logic        w_first;
  logic        w_latch;

  assign w_len_new    = (frame_len == '0) ? 16'd1 : frame_len;
  assign w_in_xfer    = in_valid && in_ready;
  assign w_out_xfer   = out_valid && out_ready;
  assign w_pipe_empty = !(r_s1_v || r_s2_v || r_s3_v);

  // State register
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Holds in_ready low during reset and releases it one cycle after
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_xfer) begin
          w_state_nxt = (w_len_new == 16'd1) ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_in_xfer && (r_cnt + 16'd1 == r_len)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pipe_empty) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_out_xfer) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic; w_first is derived from inputs directly so it does not
  // loop back through in_ready.
  always_comb begin
    in_ready  = r_en && ((r_state == ST_IDLE) || (r_state == ST_ACCUM));
    out_valid = (r_state == ST_HOLD);
    busy      = (r_state != ST_IDLE);
    w_first   = r_en && in_valid && (r_state == ST_IDLE);
    w_latch   = (r_state == ST_DRAIN) && w_pipe_empty;
  end

  // Frame length capture and beat counter
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_in_xfer) begin
      if (w_first) begin
        r_len <= w_len_new;
        r_cnt <= 16'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Stage valids shared by all lanes: S1 operands, S2 product, S3 accumulate
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s3_v <= 1'b0;
    end else begin
      r_s1_v <= w_in_xfer;
      r_s2_v <= r_s1_v;
      r_s3_v <= r_s2_v;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    if (gi < NBUILT) begin : g_built
      logic signed [DW-1:0]     r_a;
      logic signed [DW-1:0]     r_b;
      logic signed [2*DW-1:0]   r_prod;
      logic signed [ACC_W-1:0]  r_acc;
      logic                     r_ovf;
      logic signed [ACC_W-1:0]  r_oacc;
      logic                     r_oovf;
      logic signed [ACC_W:0]    w_sum;
      logic signed [ACC_W-1:0]  w_acc_nxt;
      logic                     w_pos_ovf;
      logic                     w_neg_ovf;

      // One guard bit is enough: the sum of two ACC_W-bit values always
      // fits in ACC_W+1 bits, so the top two bits disagree only on overflow.
      assign w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_prod);
      assign w_pos_ovf = !w_sum[ACC_W] && w_sum[ACC_W-1];
      assign w_neg_ovf = w_sum[ACC_W] && !w_sum[ACC_W-1];

      always_comb begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (SATURATE != 0) begin
          if (w_pos_ovf) begin
            w_acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
          end else if (w_neg_ovf) begin
            w_acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
          end
        end
      end

      always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
          r_a    <= '0;
          r_b    <= '0;
          r_prod <= '0;
          r_acc  <= '0;
          r_ovf  <= 1'b0;
          r_oacc <= '0;
          r_oovf <= 1'b0;
        end else begin
          if (w_in_xfer) begin
            r_a <= in_a[gi*DW +: DW];
            r_b <= in_b[gi*DW +: DW];
          end
          if (r_s1_v) begin
            r_prod <= (2*DW)'(r_a) * (2*DW)'(r_b);
          end
          // The previous frame has fully drained before a new first beat
          // can be accepted, so clearing never collides with an S3 add.
          if (w_first) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else if (r_s2_v) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | w_pos_ovf | w_neg_ovf;
          end
          if (w_latch) begin
            r_oacc <= r_acc;
            r_oovf <= r_ovf;
          end
        end
      end

      assign out_acc[gi*ACC_W +: ACC_W] = r_oacc;
      assign out_ovf[gi]                = r_oovf;
    end else begin : g_pruned
      logic w_unused_in;
      assign w_unused_in                = ^{in_a[gi*DW +: DW], in_b[gi*DW +: DW]};
      assign out_acc[gi*ACC_W +: ACC_W] = '0;
      assign out_ovf[gi]                = 1'b0;
    end
  end

endmodule

// File: tb/tb_board_mac_array.sv
// Bench for board_mac_array. Four instances share one input stream:
//   m : BOARD_VERSION=1, ACC_W=24, saturate
//   s : BOARD_VERSION=1, ACC_W=16, saturate
//   w : BOARD_VERSION=1, ACC_W=16, wrap
//   b : BOARD_VERSION=0, ACC_W=24, saturate (lanes 2,3 pruned)
// Their control paths are identical, so the handshake of m drives the bench.
module tb_board_mac_array;

  logic        clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic        rst;
  logic [15:0] frame_len;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic        rdy_m, rdy_s, rdy_w, rdy_b;
  logic        vld_m, vld_s, vld_w, vld_b;
  logic        bsy_m, bsy_s, bsy_w, bsy_b;
  logic [95:0] acc_m, acc_b;
  logic [63:0] acc_s, acc_w;
  logic [3:0]  ovf_m, ovf_s, ovf_w, ovf_b;

  board_mac_array #(.BOARD_VERSION(1), .NCH(4), .DW(8), .ACC_W(24), .SATURATE(1)) dut_m (
    .clk100(clk100), .rst(rst), .frame_len(frame_len), .in_valid(in_valid), .in_ready(rdy_m),
    .in_a(in_a), .in_b(in_b), .out_valid(vld_m), .out_ready(out_ready), .out_acc(acc_m),
    .out_ovf(ovf_m), .busy(bsy_m));
  board_mac_array #(.BOARD_VERSION(1), .NCH(4), .DW(8), .ACC_W(16), .SATURATE(1)) dut_s (
    .clk100(clk100), .rst(rst), .frame_len(frame_len), .in_valid(in_valid), .in_ready(rdy_s),
    .in_a(in_a), .in_b(in_b), .out_valid(vld_s), .out_ready(out_ready), .out_acc(acc_s),
    .out_ovf(ovf_s), .busy(bsy_s));
  board_mac_array #(.BOARD_VERSION(1), .NCH(4), .DW(8), .ACC_W(16), .SATURATE(0)) dut_w (
    .clk100(clk100), .rst(rst), .frame_len(frame_len), .in_valid(in_valid), .in_ready(rdy_w),
    .in_a(in_a), .in_b(in_b), .out_valid(vld_w), .out_ready(out_ready), .out_acc(acc_w),
    .out_ovf(ovf_w), .busy(bsy_w));
  board_mac_array #(.BOARD_VERSION(0), .NCH(4), .DW(8), .ACC_W(24), .SATURATE(1)) dut_b (
    .clk100(clk100), .rst(rst), .frame_len(frame_len), .in_valid(in_valid), .in_ready(rdy_b),
    .in_a(in_a), .in_b(in_b), .out_valid(vld_b), .out_ready(out_ready), .out_acc(acc_b),
    .out_ovf(ovf_b), .busy(bsy_b));

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int t_last   = 0;

  // Current frame beats, flattened: entry k*4+l is lane l of beat k
  int qa[$];
  int qb[$];

  typedef struct {
    longint v[4];
    bit     o[4];
  } res_t;

  typedef struct {
    logic [15:0] flen;
    int          nb;
    int          a[5];
    int          b[5];
    int          gmax;
    longint      e24;
    longint      e16s;
    bit          o16s;
    longint      e16w;
    bit          o16w;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint lane_s(input logic [95:0] v, input int w, input int i);
    longint r;
    r = 0;
    for (int k = 0; k < 64; k++) begin
      if (k < w) r[k] = v[i*w + k];
      else       r[k] = v[i*w + w - 1];
    end
    return r;
  endfunction

  // Reference: plain integer running sum with clamp or modular wrap
  function automatic res_t model(input int acc_w, input bit sat, input bit half);
    res_t   r;
    longint span, hi, lo, acc;
    span = longint'(1) <<< acc_w;
    hi   = span / 2 - 1;
    lo   = -(span / 2);
    for (int l = 0; l < 4; l++) begin
      acc    = 0;
      r.o[l] = 1'b0;
      if (!(half && l >= 2)) begin
        for (int k = 0; k < qa.size() / 4; k++) begin
          acc += longint'(qa[k*4 + l]) * longint'(qb[k*4 + l]);
          if (acc > hi) begin
            r.o[l] = 1'b1;
            acc = sat ? hi : acc - span;
          end else if (acc < lo) begin
            r.o[l] = 1'b1;
            acc = sat ? lo : acc + span;
          end
        end
      end
      r.v[l] = acc;
    end
    return r;
  endfunction

  function automatic res_t flat(input longint v, input bit o, input bit half);
    res_t r;
    for (int l = 0; l < 4; l++) begin
      r.v[l] = (half && l >= 2) ? 0 : v;
      r.o[l] = (half && l >= 2) ? 1'b0 : o;
    end
    return r;
  endfunction

  function automatic int rnd_op();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic push_same(input int a, input int b);
    for (int l = 0; l < 4; l++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  task automatic push_rand();
    for (int l = 0; l < 4; l++) begin
      qa.push_back(rnd_op());
      qb.push_back(rnd_op());
    end
  endtask

  task automatic drive_beat(input int k);
    for (int l = 0; l < 4; l++) begin
      in_a[l*8 +: 8] = 8'(qa[k*4 + l]);
      in_b[l*8 +: 8] = 8'(qb[k*4 + l]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send_beat(input int k, input string tag);
    int w;
    drive_beat(k);
    in_valid = 1'b1;
    w = 0;
    while (!rdy_m && w < 50) begin
      @(negedge clk100);
      w++;
    end
    chk({tag, " in_ready for beat"}, rdy_m, 1);
    t_last = cyc + 1;
    @(negedge clk100);
    in_valid = 1'b0;
  endtask

  // frame_len is scrambled after the first beat: only the first sample counts
  task automatic run_frame(input logic [15:0] flen, input int gmin, input int gmax,
                           input string tag);
    frame_len = flen;
    for (int k = 0; k < qa.size() / 4; k++) begin
      if (k > 0) repeat ($urandom_range(gmin, gmax)) @(negedge clk100);
      send_beat(k, tag);
      if (k == 0) frame_len = 16'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_out(input string tag, input bit lat);
    int w;
    w = 0;
    while (!vld_m && w < 40) begin
      @(negedge clk100);
      w++;
    end
    chk({tag, " out_valid"}, vld_m, 1);
    if (lat) chk({tag, " latency"}, cyc - t_last, 4);
    chk({tag, " in_ready in hold"}, rdy_m, 0);
  endtask

  task automatic compare(input string tag, input res_t em, input res_t es,
                         input res_t ew, input res_t eb);
    chk({tag, " s out_valid"}, vld_s, 1);
    chk({tag, " w out_valid"}, vld_w, 1);
    chk({tag, " b out_valid"}, vld_b, 1);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("%s m acc%0d", tag, l), lane_s(acc_m, 24, l), em.v[l]);
      chk($sformatf("%s m ovf%0d", tag, l), ovf_m[l], em.o[l]);
      chk($sformatf("%s s acc%0d", tag, l), lane_s({32'd0, acc_s}, 16, l), es.v[l]);
      chk($sformatf("%s s ovf%0d", tag, l), ovf_s[l], es.o[l]);
      chk($sformatf("%s w acc%0d", tag, l), lane_s({32'd0, acc_w}, 16, l), ew.v[l]);
      chk($sformatf("%s w ovf%0d", tag, l), ovf_w[l], ew.o[l]);
      chk($sformatf("%s b acc%0d", tag, l), lane_s(acc_b, 24, l), eb.v[l]);
      chk($sformatf("%s b ovf%0d", tag, l), ovf_b[l], eb.o[l]);
    end
  endtask

  task automatic compare_model(input string tag);
    compare(tag, model(24, 1'b1, 1'b0), model(16, 1'b1, 1'b0),
            model(16, 1'b0, 1'b0), model(24, 1'b1, 1'b1));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk100);
    out_ready = 1'b0;
    chk({tag, " out_valid after accept"}, vld_m, 0);
    chk({tag, " busy after accept"}, bsy_m, 0);
    chk({tag, " in_ready after accept"}, rdy_m, 1);
  endtask

  task automatic chk_reset_state(input string tag, input bit rdy_exp);
    chk({tag, " in_ready"}, rdy_m, rdy_exp);
    chk({tag, " out_valid"}, vld_m | vld_s | vld_w | vld_b, 0);
    chk({tag, " busy"}, bsy_m | bsy_s | bsy_w | bsy_b, 0);
    chk({tag, " acc zero"}, |{acc_m, acc_s, acc_w, acc_b}, 0);
    chk({tag, " ovf zero"}, |{ovf_m, ovf_s, ovf_w, ovf_b}, 0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk100);
    rst = 1'b0;
    chk({tag, " in_ready at release"}, rdy_m, 0);
    @(negedge clk100);
    chk({tag, " in_ready after release"}, rdy_m, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    frame_len = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;

    tv[0] = '{16'd3, 3, '{2, 4, -1, 0, 0}, '{3, -5, -1, 0, 0}, 0, -13, -13, 1'b0, -13, 1'b0};
    tv[1] = '{16'd4, 4, '{-128, -128, -128, -128, 0}, '{-128, -128, -128, -128, 0}, 0,
              65536, 32767, 1'b1, 0, 1'b1};
    tv[2] = '{16'd2, 2, '{3, 3, 0, 0, 0}, '{3, 3, 0, 0, 0}, 0, 18, 18, 1'b0, 18, 1'b0};
    tv[3] = '{16'd0, 1, '{7, 0, 0, 0, 0}, '{7, 0, 0, 0, 0}, 0, 49, 49, 1'b0, 49, 1'b0};
    tv[4] = '{16'd5, 5, '{1, 3, 5, -7, 9}, '{2, 4, 6, 8, -10}, 3, -102, -102, 1'b0, -102, 1'b0};
    tv[5] = '{16'd3, 3, '{-128, -128, -128, 0, 0}, '{127, 127, 127, 0, 0}, 0,
              -48768, -32768, 1'b1, 16768, 1'b1};
    tv[6] = '{16'd1, 1, '{127, 0, 0, 0, 0}, '{-128, 0, 0, 0, 0}, 0,
              -16256, -16256, 1'b0, -16256, 1'b0};

    // Reset state and in_ready release
    repeat (3) @(negedge clk100);
    chk_reset_state("reset", 1'b0);
    release_reset("reset");

    // Directed table
    foreach (tv[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      qa.delete();
      qb.delete();
      for (int k = 0; k < tv[i].nb; k++) push_same(tv[i].a[k], tv[i].b[k]);
      run_frame(tv[i].flen, (tv[i].gmax > 0) ? 1 : 0, tv[i].gmax, tag);
      wait_out(tag, 1'b1);
      compare(tag, flat(tv[i].e24, 1'b0, 1'b0), flat(tv[i].e16s, tv[i].o16s, 1'b0),
              flat(tv[i].e16w, tv[i].o16w, 1'b0), flat(tv[i].e24, 1'b0, 1'b1));
      accept(tag);
    end

    // Backpressure: result held for 10 cycles while a beat is offered
    qa.delete();
    qb.delete();
    push_rand();
    push_rand();
    run_frame(16'd2, 0, 0, "bp");
    wait_out("bp", 1'b1);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_a     = $urandom();
      in_b     = $urandom();
      compare_model($sformatf("bp hold%0d", c));
      chk($sformatf("bp hold%0d in_ready", c), rdy_m, 0);
      @(negedge clk100);
    end
    // Output transfer with a beat already waiting: taken only once idle
    qa.delete();
    qb.delete();
    push_same(5, 5);
    drive_beat(0);
    frame_len = 16'd1;
    out_ready = 1'b1;
    chk("bp in_ready at out transfer", rdy_m, 0);
    @(negedge clk100);
    out_ready = 1'b0;
    chk("bp out_valid dropped", vld_m, 0);
    chk("bp in_ready in idle", rdy_m, 1);
    t_last = cyc + 1;
    @(negedge clk100);
    in_valid = 1'b0;
    wait_out("bp next", 1'b1);
    compare_model("bp next");
    accept("bp next");

    // Reset during accumulation
    qa.delete();
    qb.delete();
    push_same(100, 100);
    push_same(100, 100);
    run_frame(16'd4, 0, 0, "rst accum");
    rst = 1'b1;
    #1;
    chk_reset_state("rst accum", 1'b0);
    release_reset("rst accum");
    qa.delete();
    qb.delete();
    push_same(2, 2);
    run_frame(16'd1, 0, 0, "after rst accum");
    wait_out("after rst accum", 1'b1);
    compare("after rst accum", flat(4, 1'b0, 1'b0), flat(4, 1'b0, 1'b0),
            flat(4, 1'b0, 1'b0), flat(4, 1'b0, 1'b1));
    accept("after rst accum");

    // Reset while holding a result
    qa.delete();
    qb.delete();
    push_rand();
    push_rand();
    run_frame(16'd2, 0, 0, "rst hold");
    wait_out("rst hold", 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_state("rst hold", 1'b0);
    release_reset("rst hold");
    qa.delete();
    qb.delete();
    push_same(2, 2);
    run_frame(16'd1, 0, 0, "after rst hold");
    wait_out("after rst hold", 1'b1);
    compare("after rst hold", flat(4, 1'b0, 1'b0), flat(4, 1'b0, 1'b0),
            flat(4, 1'b0, 1'b0), flat(4, 1'b0, 1'b1));
    accept("after rst hold");

    // Long frame exercising the upper counter bits
    qa.delete();
    qb.delete();
    for (int k = 0; k < 300; k++) push_same(1, 1);
    run_frame(16'd300, 0, 0, "long");
    wait_out("long", 1'b1);
    compare("long", flat(300, 1'b0, 1'b0), flat(300, 1'b0, 1'b0),
            flat(300, 1'b0, 1'b0), flat(300, 1'b0, 1'b1));
    accept("long");

    // Random frames against the reference model
    for (int f = 0; f < 40; f++) begin
      logic [15:0] fl;
      int          nb;
      string       tag;
      tag = $sformatf("rnd%0d", f);
      fl  = 16'($urandom_range(0, 8));
      nb  = (fl == 0) ? 1 : int'(fl);
      qa.delete();
      qb.delete();
      for (int k = 0; k < nb; k++) push_rand();
      run_frame(fl, 0, $urandom_range(0, 3), tag);
      wait_out(tag, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk100);
      compare_model(tag);
      accept(tag);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_mac_array.md
Name: board_mac_array

Overview:
- Parametrised, multi-lane signed multiply-accumulate engine. It is the successor to the single fixed 8x8 product path in the board top level.
- Accepts NCH lanes of signed operand pairs through a valid/ready stream. Accumulates products per lane over a programmable frame length, then presents one result vector per frame.
- BOARD_VERSION prunes the lanes a given board does not populate, so one source file serves both boards.

Parameters:
- BOARD_VERSION, 0, board variant. 0 = lanes 0..NCH/2-1 built. 1 = all NCH lanes built.
- NCH, 4, lane count. Even, >=2.
- DW, 8, signed operand width per lane.
- ACC_W, 24, signed accumulator/result width. Must be >= 2*DW.
- SATURATE, 1, 1 = clamp on overflow. 0 = two's-complement wrap.

Ports:
- clk100 in 1: single clock, all logic on rising edge.
- rst in 1: asynchronous, active-high reset.
- frame_len in 16: beats per frame. Sampled on first beat of a frame.
- in_valid in 1: input beat valid.
- in_ready out 1: engine can accept a beat.
- in_a in NCH*DW: lane i operand at bits [i*DW +: DW], signed.
- in_b in NCH*DW: lane i operand, signed.
- out_valid out 1: result vector valid.
- out_ready in 1: consumer accepts result.
- out_acc out NCH*ACC_W: lane i result at [i*ACC_W +: ACC_W], signed.
- out_ovf out NCH: lane i overflowed at least once during the frame (sticky).
- busy out 1: state != IDLE.

Behaviour:
- Reset (async assert, sync deassert expected upstream) forces:
  - in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
  - All pipeline registers, accumulators and counters = 0. State = IDLE.
  - in_ready rises the first cycle after rst deasserts.
- A beat transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
- Pipeline per lane, 3 stages:
  - S1 registers operands.
  - S2 registers full-width product (2*DW signed).
  - S3 adds sign-extended product into the accumulator.
  - Valid travels with the data through S1-S3.
- State machine:
  - IDLE: in_ready=1. First transfer latches len = (frame_len==0) ? 1 : frame_len, sets beat_cnt=1, clears accumulators and ovf, and goes to ACCUM. If len==1 it goes directly to DRAIN.
  - ACCUM: in_ready=1. Each transfer increments beat_cnt. The transfer making beat_cnt==len goes to DRAIN.
  - DRAIN: in_ready=0. Waits until S1-S3 are empty, then latches accumulators into out_acc/out_ovf, sets out_valid=1, and goes to HOLD.
  - HOLD: in_ready=0. out_acc/out_ovf are held stable while out_valid && !out_ready. On transfer: out_valid=0, go to IDLE.
- Latency: last beat accepted at cycle T gives out_valid=1 at cycle T+4. in_ready returns the cycle after the output transfer.
- Beats with in_valid=0 inside a frame are gaps. Gaps do not count and the accumulator holds.
- Arithmetic:
  - Products and sums are signed.
  - SATURATE=1: a sum above 2^(ACC_W-1)-1 or below -2^(ACC_W-1) clamps to that limit and sets ovf for the lane. Later products still add from the clamped value.
  - SATURATE=0: the sum wraps. ovf still flags a sign-overflow event.
- Pruned lanes (BOARD_VERSION==0, lane >= NCH/2): no registers generated. out_acc slice and out_ovf bit are constant 0. Their inputs are ignored.
- Changes to frame_len mid-frame are ignored until the next IDLE capture.
- beat_cnt is 16 bits. len=65535 must complete without wrap.
- rst asserted mid-frame or in HOLD: the frame is discarded immediately, with no partial output.
- Simultaneous output transfer and new in_valid in HOLD: the new beat is not accepted that cycle (in_ready=0). It is accepted in IDLE on the next cycle.

Test Plan:
- Basic frame: NCH=4, BOARD_VERSION=1, frame_len=3. Lane0 a/b = (2,3),(4,-5),(-1,-1) -> out_acc lane0 = 6-20+1 = -13. out_valid exactly 4 cycles after the third beat. ovf=0.
- Saturation: DW=8, ACC_W=16, SATURATE=1, frame_len=4. All beats (-128,-128), product 16384 -> lane holds 32767, ovf=1. Repeat with SATURATE=0 -> lane = 0 (wrap), ovf=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_acc stable, in_ready=0 throughout. Accept, then next frame starts cleanly from 0.
- Board pruning: BOARD_VERSION=0, NCH=4, all lanes driven (3,3), frame_len=2 -> lanes 0,1 = 18, lanes 2,3 = 0, out_ovf[3:2]=0.
- Edge lengths and gaps: frame_len=0 -> treated as 1, single beat (7,7) gives 49. frame_len=5 with in_valid gaps of 1-3 cycles between beats -> correct sum, gaps not counted.
- Reset mid-operation: assert rst during ACCUM after 2 of 4 beats, then during HOLD -> all outputs 0 immediately. The following frame (2,2)x1 gives 4, not polluted by old data.
